mem_burst_arbiter: RTL and testbench
====================================

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter DATA_WIDTH, default 32, beat width.
REQ-003 Parameter LEN_WIDTH, default 4, burst-length field width; length encodes beats-1.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_i  in  2  per-requester one-cycle request pulse; index 0 is the instruction cache, index 1 is the data cache.
REQ-007 addr0_i/addr1_i  in  ADDR_WIDTH  block-aligned burst address, sampled with req_i.
REQ-008 len0_i/len1_i  in  LEN_WIDTH  burst length (beats-1), sampled with req_i.
REQ-009 rdata_o  out  DATA_WIDTH  beat data, broadcast to both requesters.
REQ-010 rvalid_o  out  2  per-requester beat valid.
REQ-011 rlast_o  out  2  per-requester final-beat flag.
REQ-012 busy_o  out  2  per-requester flag: pending or in service.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_addr  out  ADDR_WIDTH  memory burst address.
REQ-015 mem_burst_len  out  LEN_WIDTH  memory burst length.
REQ-016 mem_ready  in  1  memory accepts the request.
REQ-017 mem_data  in  DATA_WIDTH  memory beat data.
REQ-018 mem_valid  in  1  memory beat valid.
REQ-019 mem_last  in  1  memory final beat.

Function
REQ-020 Each requester has a pending flag; req_i[n] sets it and captures addrN_i/lenN_i. A request arriving while that flag is already set is ignored.
REQ-021 The FSM has states IDLE, ISSUE and XFER.
- IDLE->ISSUE: any flag is pending; the grant is chosen in the same cycle.
- ISSUE->XFER: on the first cycle with mem_req and mem_ready both high.
- XFER->IDLE: on the completing beat (REQ-025).
REQ-022 In ISSUE, mem_req is 1 and mem_addr/mem_burst_len hold the granted request's captured values, stable until accepted. In all other states mem_req, mem_addr and mem_burst_len are 0.
REQ-023 In XFER:
- rvalid_o[g] = mem_valid.
- rdata_o = mem_data.
- rlast_o[g] = completing beat.
- The non-granted bits of rvalid_o/rlast_o are 0.
- This routing is combinational (zero latency).
REQ-024 A LEN_WIDTH beat counter clears on entry to XFER and increments on each mem_valid beat.
REQ-025 The completing beat is mem_valid with either mem_last set or counter == captured length, whichever comes first. Beats after it are dropped.
REQ-026 On the completing beat, the granted pending flag clears. If req_i for the same requester arrives in that cycle, the set takes priority and the new request is captured.
REQ-027 mem_valid outside XFER is ignored.
REQ-028 busy_o[n] = pending[n].
REQ-029 Requests arriving in any state are captured; arbitration occurs only in IDLE, so there is one idle cycle between bursts.

Reset
REQ-030 While rst_n is low:
- state = IDLE, both pending flags 0, counter 0, round-robin pointer 0, captured address/length 0.
- All outputs are 0.
REQ-031 Reset asserted mid-burst aborts the burst immediately; no rvalid_o is issued afterwards until a new grant.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined:
- When both flags are pending, the grant goes to the requester not served last.
- The pointer updates on each completing beat.
REQ-033 With ARB_ROUND_ROBIN_EN undefined, requester 0 (instruction cache) always wins ties and the pointer logic is absent.

Structure
REQ-034 A shared package holds the FSM state enum, the requester index constants (REQ_ICACHE=0, REQ_DCACHE=1) and the default width constants.
REQ-035 One sub-module, arb_request_slot, holds one pending flag with its captured address and length; it is instantiated twice.

Verification
REQ-036 Single requester 0 burst: req_i=01, addr0=0x100, len0=7, mem_ready one cycle later, 8 beats -> 8 rvalid_o[0] pulses, rlast_o[0] on beat 8, busy_o[0] clears, rvalid_o[1] never set.
REQ-037 Simultaneous requests: req_i=11 with the macro defined -> requester 0 is served first, then requester 1 (addr1=0x200). A second simultaneous pair -> requester 1 is served first. With the macro undefined -> requester 0 is served first both times.
REQ-038 Early mem_last: len=7 with mem_last on beat 3 -> rlast_o on beat 3, FSM returns to IDLE, extra beats are dropped.
REQ-039 Backpressure: mem_ready held low for 5 cycles -> mem_req, mem_addr and mem_burst_len stay stable throughout; the transfer starts after acceptance.
REQ-040 Reset mid-burst: rst_n low after beat 2 -> all outputs 0 at once; no further rvalid_o.
REQ-041 Re-request on the completing beat: req_i[0] pulses in the same cycle as rlast_o[0] -> busy_o[0] stays 1 and a new burst is issued.

Source files
------------

// File: rtl/mem_burst_arbiter_pkg.sv
// Shared definitions for the two-requester memory burst arbiter:
// FSM states, requester indices and default widths.
package mem_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 4;

endpackage

// File: rtl/mem_burst_arbiter_slot.sv
// One requester's pending flag plus its captured burst address and length.
// A new request is taken when idle, or in the same cycle the current one completes.
module arb_request_slot
  import mem_burst_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN_WIDTH-1:0]  len
);

  logic                  pending_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic                  capture;

  // Set wins over clear so a re-request on the completing beat is kept.
  assign capture = set && (!pending_reg || clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      addr_reg    <= '0;
      len_reg     <= '0;
    end else if (capture) begin
      pending_reg <= 1'b1;
      addr_reg    <= addr_in;
      len_reg     <= len_in;
    end else if (clr) begin
      pending_reg <= 1'b0;
    end
  end

  assign pending = pending_reg;
  assign addr    = addr_reg;
  assign len     = len_reg;

endmodule

// File: rtl/mem_burst_arbiter.sv
// Arbitrates instruction/data cache burst reads onto one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the icache always wins.
module mem_burst_arbiter
  import mem_burst_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [LEN_WIDTH-1:0]  len0_i,
  input  logic [LEN_WIDTH-1:0]  len1_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rvalid_o,
  output logic [1:0]            rlast_o,
  output logic [1:0]            busy_o,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LEN_WIDTH-1:0]  mem_burst_len,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_valid,
  input  logic                  mem_last
);

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic [LEN_WIDTH-1:0]  cnt_reg;
  logic [1:0]            pending;
  logic [1:0]            clr;
  logic [ADDR_WIDTH-1:0] slot_addr [2];
  logic [LEN_WIDTH-1:0]  slot_len  [2];
  logic                  accept;
  logic                  complete;
  logic                  pick;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      arb_request_slot #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
      ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (req_i[gi]),
        .clr    (clr[gi]),
        .addr_in((gi == REQ_ICACHE) ? addr0_i : addr1_i),
        .len_in ((gi == REQ_ICACHE) ? len0_i : len1_i),
        .pending(pending[gi]),
        .addr   (slot_addr[gi]),
        .len    (slot_len[gi])
      );
    end
  endgenerate

  assign accept   = (state_reg == ST_ISSUE) && mem_ready;
  assign complete = (state_reg == ST_XFER) && mem_valid &&
                    (mem_last || (cnt_reg == slot_len[grant_reg]));
  assign clr[REQ_ICACHE] = complete && !grant_reg;
  assign clr[REQ_DCACHE] = complete && grant_reg;
  assign busy_o = pending;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer holds the requester preferred on the next tie.
  logic rr_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= 1'b0;
    end else if (complete) begin
      rr_ptr_reg <= !grant_reg;
    end
  end

  assign pick = (&pending) ? rr_ptr_reg : !pending[REQ_ICACHE];
`else
  assign pick = !pending[REQ_ICACHE];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      if (accept) begin
        cnt_reg <= '0;
      end else if ((state_reg == ST_XFER) && mem_valid) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|pending) begin
          state_next = ST_ISSUE;
          grant_next = pick;
        end
      end
      ST_ISSUE: if (mem_ready) state_next = ST_XFER;
      ST_XFER:  if (complete) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_addr      = '0;
    mem_burst_len = '0;
    rdata_o       = '0;
    rvalid_o      = '0;
    rlast_o       = '0;
    case (state_reg)
      ST_ISSUE: begin
        mem_req       = 1'b1;
        mem_addr      = slot_addr[grant_reg];
        mem_burst_len = slot_len[grant_reg];
      end
      ST_XFER: begin
        rdata_o             = mem_data;
        rvalid_o[grant_reg] = mem_valid;
        rlast_o[grant_reg]  = complete;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: stimulus queues expected issues and
// beats, a memory model and a beat monitor pop and compare.
`timescale 1ns/1ps
module tb_mem_burst_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [LW-1:0] len0_i, len1_i;
  logic [DW-1:0] rdata_o;
  logic [1:0]    rvalid_o, rlast_o, busy_o;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_burst_len;
  logic          mem_ready;
  logic [DW-1:0] mem_data;
  logic          mem_valid, mem_last;

  always #5 clk = ~clk;

  mem_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .len0_i(len0_i), .len1_i(len1_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rlast_o(rlast_o), .busy_o(busy_o),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_burst_len(mem_burst_len),
    .mem_ready(mem_ready), .mem_data(mem_data), .mem_valid(mem_valid), .mem_last(mem_last)
  );

  typedef struct packed {logic id; logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [AW-1:0] addr; logic [LW-1:0] len;} issue_t;

  beat_t  exp_beats[$];
  issue_t exp_issue[$];
  int n_checks = 0;
  int n_errors = 0;
  int beats_seen = 0;
  int ready_delay = 1;
  int last_at = 99;
  int extra = 1;
  bit model_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic push_burst(input logic id, input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input int nbeats, input bit last_flag);
    beat_t  b;
    issue_t s;
    s.addr = a;
    s.len  = l;
    exp_issue.push_back(s);
    for (int i = 0; i < nbeats; i++) begin
      b.id   = id;
      b.data = a + i;
      b.last = last_flag && (i == nbeats - 1);
      exp_beats.push_back(b);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [AW-1:0] a0, input logic [LW-1:0] l0,
                      input logic [AW-1:0] a1, input logic [LW-1:0] l1);
    @(posedge clk); #1;
    req_i = m; addr0_i = a0; len0_i = l0; addr1_i = a1; len1_i = l1;
    @(posedge clk); #1;
    req_i = 2'b00;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(busy_o == 2'b00 && !model_busy && exp_beats.size() == 0 && !mem_req) && cyc < 500);
    if (cyc >= 500) begin
      $display("FAIL %s_timeout: got busy=%b beats_left=%0d, expected idle", name, busy_o, exp_beats.size());
      n_checks++;
      n_errors++;
      exp_beats.delete();
      exp_issue.delete();
    end
  endtask

  // Memory model: checks each issued request, applies backpressure, returns beats.
  initial begin : mem_model
    issue_t        e;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int            nb;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_last = 1'b0; mem_data = '0;
    model_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        model_busy = 1'b1;
        a = mem_addr;
        l = mem_burst_len;
        $display("issue addr=0x%0h len=%0d", a, l);
        if (exp_issue.size() == 0) begin
          fail("unexpected_issue");
        end else begin
          e = exp_issue.pop_front();
          check("issue_addr", a, e.addr);
          check("issue_len", l, e.len);
        end
        for (int d = 0; d < ready_delay; d++) begin
          @(negedge clk);
          check("hold_req", mem_req, 1);
          check("hold_addr", mem_addr, a);
          check("hold_len", mem_burst_len, l);
          @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        nb = (last_at < int'(l) + 1) ? last_at + 1 : int'(l) + 1;
        for (int i = 0; i < nb + extra; i++) begin
          mem_valid = 1'b1;
          mem_data  = a + i;
          mem_last  = (i == last_at);
          @(posedge clk); #1;
        end
        mem_valid = 1'b0; mem_last = 1'b0; mem_data = '0;
        model_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rlast_o[g] && !rvalid_o[g]) fail($sformatf("rlast_without_rvalid%0d", g));
        if (rvalid_o[g]) begin
          beats_seen++;
          if (exp_beats.size() == 0) begin
            fail($sformatf("unexpected_beat_req%0d_data%0h", g, rdata_o));
          end else begin
            e = exp_beats.pop_front();
            check("beat_req", g, e.id);
            check("beat_data", rdata_o, e.data);
            check("beat_last", rlast_o[g], e.last);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int  base;
    int  cyc;
    bit  found;
    rst_n = 1'b0;
    req_i = 2'b11; addr0_i = 32'h111; addr1_i = 32'h222; len0_i = 4'd3; len1_i = 4'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rlast", rlast_o, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_len", mem_burst_len, 0);
    check("rst_rdata", rdata_o, 0);
    @(posedge clk); #1;
    req_i = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous pair from reset: icache first in both builds.
    push_burst(0, 32'h100, 4'd3, 4, 1);
    push_burst(1, 32'h200, 4'd3, 4, 1);
    send(2'b11, 32'h100, 4'd3, 32'h200, 4'd3);
    wait_idle("pair1");

    // Single icache burst of 8 beats.
    push_burst(0, 32'h100, 4'd7, 8, 1);
    send(2'b01, 32'h100, 4'd7, 32'h0, 4'd0);
    wait_idle("single8");
    check("busy0_clear", busy_o[0], 0);

    // Second pair: icache was served last, so round-robin favours dcache.
`ifdef ARB_ROUND_ROBIN_EN
    push_burst(1, 32'h400, 4'd5, 6, 1);
    push_burst(0, 32'h300, 4'd2, 3, 1);
`else
    push_burst(0, 32'h300, 4'd2, 3, 1);
    push_burst(1, 32'h400, 4'd5, 6, 1);
`endif
    send(2'b11, 32'h300, 4'd2, 32'h400, 4'd5);
    wait_idle("pair2");

    // Early mem_last on beat 3 of an 8-beat request; trailing beats dropped.
    last_at = 2; extra = 2;
    push_burst(0, 32'h500, 4'd7, 3, 1);
    send(2'b01, 32'h500, 4'd7, 32'h0, 4'd0);
    wait_idle("early_last");
    check("early_last_idle_req", mem_req, 0);
    last_at = 99; extra = 1;

    // Backpressure: mem_ready low for 5 cycles.
    ready_delay = 5;
    push_burst(1, 32'h600, 4'd3, 4, 1);
    send(2'b10, 32'h0, 4'd0, 32'h600, 4'd3);
    wait_idle("backpressure");
    ready_delay = 1;

    // Re-request in the cycle of the completing beat.
    push_burst(0, 32'h700, 4'd1, 2, 1);
    push_burst(0, 32'h780, 4'd2, 3, 1);
    send(2'b01, 32'h700, 4'd1, 32'h0, 4'd0);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #2;
      if (rlast_o[0]) begin
        found = 1'b1;
        req_i = 2'b01; addr0_i = 32'h780; len0_i = 4'd2;
        @(posedge clk); #1;
        req_i = 2'b00;
        @(negedge clk);
        check("busy0_held", busy_o[0], 1);
      end
    end
    if (!found) fail("rerequest_no_rlast");
    wait_idle("rerequest");

    // Reset after beat 2 of an 8-beat dcache burst.
    push_burst(1, 32'h800, 4'd7, 2, 0);
    base = beats_seen;
    send(2'b10, 32'h0, 4'd0, 32'h800, 4'd7);
    cyc = 0;
    while (beats_seen < base + 2 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 200) fail("midreset_beats_timeout");
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", rvalid_o, 0);
    check("midrst_rlast", rlast_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_len", mem_burst_len, 0);
    check("midrst_rdata", rdata_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("after_reset");

    // Single-beat burst (len 0) after reset.
    push_burst(0, 32'h900, 4'd0, 1, 1);
    send(2'b01, 32'h900, 4'd0, 32'h0, 4'd0);
    wait_idle("len0");

    repeat (5) @(negedge clk);
    check("leftover_issues", exp_issue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
